// File: rtl/keccak_squeeze.sv
// rtl/keccak_squeeze.sv - Keccak squeeze-side reader streaming rate lanes as 64-bit words
//
// Captures a permuted 1600-bit state and emits its first RATE_LANES lanes over a
// valid/ready stream. If more words are requested than one block holds, it asks
// the permutation core for another permutation and continues from the new state.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, out_words  begin a squeeze of out_words 64-bit words (sampled in IDLE)
//   state_in          permuted state; lane i = state_in[i*64 +: 64]
//   perm_done         core pulse; state_in valid in that cycle (used only in WAIT)
//   perm_req          one-cycle request to permute perm_state
//   perm_state        internal state buffer presented to the core
//   out_data          current lane, out_valid / out_ready handshake
//   busy              high outside IDLE
//   done              one-cycle pulse after the final word transfer
//
// Build option: KECCAK_SQUEEZE_BYTE_SWAP_EN byte-reverses out_data (lane byte 0
// on out_data[63:56]); otherwise the lane is presented unchanged.

module keccak_squeeze #(
  parameter int RATE_LANES = 21,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  out_words,
  input  logic [1599:0]     state_in,
  input  logic              perm_done,
  output logic              perm_req,
  output logic [1599:0]     perm_state,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EMIT = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  state_t           state_q, state_d;
  logic [1599:0]    perm_state_q;
  logic [63:0]      data_q;
  logic [4:0]       idx_q;
  logic [LEN_W-1:0] rem_q;
  logic             xfer;
  logic             last_word;

  function automatic logic [63:0] lane_of(input logic [1599:0] s, input logic [4:0] i);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) begin
      if (i == 5'(k)) r = s[k*64 +: 64];
    end
    return r;
  endfunction

  assign xfer      = (state_q == S_EMIT) && out_ready;
  assign last_word = (rem_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (out_words == '0) ? S_FIN : S_EMIT;
      S_EMIT: begin
        if (xfer) begin
          if (last_word)              state_d = S_FIN;
          else if (idx_q == LAST_IDX) state_d = S_REQ;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (perm_done) state_d = S_EMIT;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_valid = (state_q == S_EMIT);
    perm_req  = (state_q == S_REQ);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
  end

  // Datapath: the word register is loaded one cycle ahead so the lane is
  // already registered on the cycle out_valid rises or a transfer completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perm_state_q <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            perm_state_q <= state_in;
            data_q       <= lane_of(state_in, 5'd0);
            rem_q        <= out_words;
            idx_q        <= '0;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            rem_q <= rem_q - LEN_W'(1);
            idx_q <= idx_q + 5'd1;
            // Never fetch a lane beyond the rate; the wrap goes through REQ/WAIT.
            if (idx_q != LAST_IDX) data_q <= lane_of(perm_state_q, idx_q + 5'd1);
          end
        end
        S_REQ: idx_q <= '0;
        S_WAIT: begin
          if (perm_done) begin
            perm_state_q <= state_in;
            data_q       <= lane_of(state_in, 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign perm_state = perm_state_q;

`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
  always_comb begin
    out_data = '0;
    for (int b = 0; b < 8; b++) out_data[(7-b)*8 +: 8] = data_q[b*8 +: 8];
  end
`else
  assign out_data = data_q;
`endif

endmodule

// File: tb/tb_keccak_squeeze.sv
// tb/tb_keccak_squeeze.sv - scoreboard bench for keccak_squeeze with a word-level reference model

module tb_keccak_squeeze;

  localparam int R  = 21;
  localparam int LW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [LW-1:0]  out_words = '0;
  logic [1599:0]  stim_state = '0;
  logic [1599:0]  resp_state = '0;
  logic [1599:0]  state_in;
  logic           resp_pd = 1'b0;
  logic           spur_pd = 1'b0;
  logic           perm_done;
  logic           perm_req;
  logic [1599:0]  perm_state;
  logic [63:0]    out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;
  logic           done;

  assign perm_done = resp_pd | spur_pd;
  assign state_in  = resp_pd ? resp_state : stim_state;

  always #5 clk = ~clk;

  keccak_squeeze #(.RATE_LANES(R), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_words(out_words),
    .state_in(state_in), .perm_done(perm_done), .perm_req(perm_req),
    .perm_state(perm_state), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word k of a squeeze is lane (k mod R) of block (k div R).
  function automatic logic [63:0] present(input logic [63:0] lane);
`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[(7-b)*8 +: 8] = lane[b*8 +: 8];
    return r;
`else
    return lane;
`endif
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [1599:0] dir_state(input logic [63:0] base, input logic [63:0] step);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = base + step * 64'(i);
    return s;
  endfunction

  // Scoreboard storage: main writes, monitor / responder read with their own indices.
  logic [63:0]   exp_arr [0:4095];
  int            xfer_cyc [0:4095];
  logic [1599:0] blk_arr [0:255];
  int exp_wr = 0, exp_rd = 0;
  int blk_wr = 0, blk_rd = 0;
  int first_req = 0, first_ack = 0;
  int zero_req = 0, zero_ack = 0;
  int pd_req = 0, pd_ack = 0;
  int cyc = 0, perm_cnt = 0, done_cnt = 0;
  int resp_delay = 4;
  int ready_mode = 0;
  int launch_id = 0;
  logic pend = 1'b0;

  // Monitor
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        done_due = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_rd = exp_wr; first_ack = first_req; zero_ack = zero_req; pd_ack = pd_req;
      prev_stall = 1'b0; done_due = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, prev_data);
      end
      if (first_ack != first_req) begin
        first_ack = first_req;
        check("valid_after_start", 64'(out_valid), 64'd1);
      end
      if (pd_ack != pd_req) begin
        pd_ack = pd_req;
        check("valid_after_perm_done", 64'(out_valid), 64'd1);
      end
      if (pend) check("valid_while_waiting", 64'(out_valid), 64'd0);
      if (zero_ack != zero_req) begin
        zero_ack = zero_req;
        done_due = 1'b1;
      end
      if (done_due) begin
        check("done_pulse", 64'(done), 64'd1);
        check("valid_at_done", 64'(out_valid), 64'd0);
        done_cnt++;
        done_due = 1'b0;
      end else begin
        check("done_idle", 64'(done), 64'd0);
      end
      if (perm_req) perm_cnt++;
      if (out_valid && out_ready) begin
        tests++;
        if (exp_rd == exp_wr) begin
          fails++;
          $display("FAIL extra_word: got %h expected no transfer", out_data);
        end else begin
          if (out_data !== exp_arr[exp_rd]) begin
            fails++;
            $display("FAIL word[%0d]: got %h expected %h", exp_rd, out_data, exp_arr[exp_rd]);
          end
          xfer_cyc[exp_rd] = cyc;
          exp_rd++;
          if (exp_rd == exp_wr) done_due = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Permutation core stand-in: answers each perm_req resp_delay cycles later.
  always begin
    @(negedge clk);
    if (!rst) begin
      blk_rd = blk_wr;
      pend = 1'b0;
    end else if (perm_req) begin
      pend = 1'b1;
      repeat (resp_delay) @(posedge clk);
      #1;
      resp_state = blk_arr[blk_rd[7:0]];
      blk_rd++;
      resp_pd = 1'b1;
      @(posedge clk);
      #1;
      resp_pd = 1'b0;
      pend = 1'b0;
      pd_req++;
    end
  end

  // Consumer ready driver
  logic [0:4] pat = 5'b11001;
  int seen_id = 0, k = 0;
  always begin
    @(posedge clk);
    #2;
    if (launch_id != seen_id) begin seen_id = launch_id; k = 0; end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (k < 5) ? pat[k] : 1'b1;
    endcase
    k++;
  end

  int exp_perm, dc0, base;

  task automatic launch(input int n, input logic [1599:0] s0, input logic [1599:0] s1);
    logic [1599:0] cur [0:7];
    int nb;
    nb = (n + R - 1) / R;
    cur[0] = s0;
    cur[1] = s1;
    for (int j = 2; j < 8; j++) cur[j] = rand_state();
    for (int j = 1; j < nb; j++) begin
      blk_arr[blk_wr[7:0]] = cur[j];
      blk_wr++;
    end
    base = exp_wr;
    for (int w = 0; w < n; w++) begin
      exp_arr[exp_wr] = present(cur[w / R][(w % R)*64 +: 64]);
      exp_wr++;
    end
    exp_perm = perm_cnt + ((n == 0) ? 0 : nb - 1);
    dc0 = done_cnt;
    stim_state = s0;
    out_words  = LW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    launch_id++;
    if (n == 0) zero_req++;
    else        first_req++;
  endtask

  task automatic finish_sq(input string tag, input int n, input bit streamed);
    int t;
    t = 0;
    while (done_cnt == dc0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 64'(t < 3000), 64'd1);
    @(negedge clk);
    #1;
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_perm_reqs"}, 64'(perm_cnt), 64'(exp_perm));
    check({tag, "_words_left"}, 64'(exp_wr - exp_rd), 64'd0);
    check({tag, "_perms_left"}, 64'(blk_wr - blk_rd), 64'd0);
    if (streamed && n > 0)
      check({tag, "_back_to_back"}, 64'(xfer_cyc[base + n - 1] - xfer_cyc[base]), 64'(n - 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_perm_req", 64'(perm_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_perm_state", 64'(perm_state == '0), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    ready_mode = 0;
    launch(3, dir_state(64'd0, 64'h0101010101010101), rand_state());
    finish_sq("single", 3, 1'b1);

    launch(25, dir_state(64'd0, 64'h0101010101010101), dir_state(64'hA5A5A5A5_00000000, 64'd1));
    finish_sq("multi", 25, 1'b0);

    ready_mode = 2;
    launch(8, rand_state(), rand_state());
    finish_sq("backpressure", 8, 1'b0);

    ready_mode = 0;
    launch(0, rand_state(), rand_state());
    finish_sq("zero_len", 0, 1'b0);

    launch(21, rand_state(), rand_state());
    finish_sq("exact_block", 21, 1'b1);

    launch(15, rand_state(), rand_state());
    @(posedge clk);
    #1;
    start = 1'b1; out_words = LW'(5); stim_state = rand_state(); spur_pd = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; spur_pd = 1'b0;
    finish_sq("spurious", 15, 1'b1);

    launch(25, rand_state(), rand_state());
    t = 0;
    while (exp_rd < base + 10 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reset_reach_word10", 64'(t < 500), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_perm_req", 64'(perm_req), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_perm_state", 64'(perm_state == '0), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    launch(2, rand_state(), rand_state());
    finish_sq("after_reset", 2, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ready_mode = 1;
      resp_delay = $urandom_range(1, 6);
      n = $urandom_range(0, 70);
      launch(n, rand_state(), rand_state());
      finish_sq("random", n, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Squeeze-side reader of the Keccak permutation state.
- Captures a permuted 1600-bit state and streams its rate lanes out as 64-bit words over a valid/ready handshake.
- When the caller requests more words than one rate block holds, it requests further permutations.
- Sits between the permutation core and the Kyber sampling/XOF consumers (SHAKE128 matrix expansion, SHAKE256 PRF).

Parameters:
- RATE_LANES, 21, number of 64-bit lanes emitted per block. 21 = SHAKE128, 17 = SHAKE256/SHA3-256. Legal range 1..24.
- LEN_W, 16, width of the requested word count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a squeeze; sampled only in IDLE.
- out_words  in  LEN_W  total 64-bit words to emit; sampled with start.
- state_in  in  1600  permuted state from the permutation core; lane i = state_in[i*64 +: 64], i = x+5y.
- perm_done  in  1  one-cycle pulse from the core; state_in is valid in that cycle.
- perm_req  out  1  one-cycle pulse requesting a permutation of perm_state.
- perm_state  out  1600  internal state buffer, presented to the core.
- out_data  out  64  current lane.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final word transfer.

Behaviour:
- Reset (rst=0, async) values:
  - All outputs 0; perm_state 0.
  - FSM in IDLE; lane index 0; remaining-word count 0.
- FSM states:
  - IDLE: on start, register state_in into perm_state, remaining := out_words, index := 0.
    - If out_words = 0, go to FIN.
    - Otherwise go to EMIT.
  - EMIT: out_valid=1, out_data = perm_state lane[index] (registered).
    - A transfer is out_valid && out_ready in the same cycle. On a transfer, remaining decrements and index increments.
    - If remaining reaches 0, go to FIN.
    - Else if index reaches RATE_LANES, go to REQ.
    - Else stay in EMIT and present the next lane in the following cycle.
  - REQ: perm_req=1 for exactly one cycle, out_valid=0, index := 0; go to WAIT.
  - WAIT: out_valid=0. On perm_done, capture state_in into perm_state and go to EMIT.
  - FIN: done=1 for one cycle; go to IDLE.
- Latency:
  - start at edge T: out_valid high from T+1; lane 0 is valid at T+1.
  - perm_done at edge P: out_valid high from P+1.
  - Last transfer at edge L: done high in cycle L+1; busy low from L+2.
- Handshake rules:
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - Back-to-back transfers run at one word per cycle within a block.
- Boundary conditions:
  - out_words equal to an exact multiple of RATE_LANES: no trailing perm_req; go straight to FIN after the last lane.
  - Index wrap happens only through REQ/WAIT; a lane index at or above RATE_LANES is never emitted.
  - start while busy: ignored.
  - perm_done outside WAIT: ignored; perm_state unchanged.
  - perm_done arriving in the same cycle as perm_req is not possible by protocol; the block ignores it.
  - out_ready while out_valid=0: no effect.
  - rst asserted mid-operation: immediate return to reset values. No done pulse; perm_req forced low.
- Width rule: remaining is LEN_W bits. out_words up to 2^LEN_W-1 is supported; no wrap.

Optional Feature:
- Macro: KECCAK_SQUEEZE_BYTE_SWAP_EN.
- Defined: out_data is the byte-reversed lane (lane byte 0 appears on out_data[63:56]), for big-endian byte-stream consumers.
- Undefined: out_data is the lane unchanged, little-endian as in the state (lane byte 0 on out_data[7:0]).
- Handshake and timing are identical in both builds.

Test Plan:
- Single block: RATE_LANES=21, state_in lane i = 64'h0101010101010101*i, out_words=3, out_ready=1 → out_data 0x00…00, 0x0101…01, 0x0202…02 on 3 consecutive cycles. done 1 cycle later. perm_req never asserted.
- Multi-block: out_words=25, perm_done returned 4 cycles after perm_req with lane i = 64'hA5A5A5A5_00000000+i.
  - Expect 21 words, then one perm_req pulse, then no out_valid until perm_done+1.
  - Then words A5A5A5A5_00000000..A5A5A5A5_00000003, then done.
- Backpressure: out_ready toggles 1,0,0,1 during lane 2 → out_data holds lane 2 across the stall; no lane is skipped or duplicated.
- Zero length / exact block:
  - out_words=0 → done at T+1 with no out_valid.
  - out_words=21 → 21 words, no perm_req, then done.
- Reset mid-stream: rst low at word 10 of 25 → all outputs 0 asynchronously. After release, start with out_words=2 emits lanes 0,1 of the newly captured state.
- Spurious inputs:
  - start pulsed during EMIT → no effect on count or data.
  - perm_done pulsed during EMIT → perm_state and out_data unchanged.
